// File: rtl/move_transmitter_pkg.sv
// Shared constants for the Trax move transmit path: move field layout, ASCII codes,
// FSM state encoding and small encoding helpers.
package move_transmitter_pkg;

    localparam int MOVE_W   = 22;
    localparam int COL_W    = 8;
    localparam int ROW_W    = 12;
    localparam int TILE_W   = 2;
    localparam int COL_LSB  = 14;
    localparam int ROW_LSB  = 2;
    localparam int TILE_LSB = 0;
    localparam int BCD_W    = 12;

    localparam logic [COL_W-1:0] COL_MAX = 8'd26;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int ROW_MAX_DEF      = 999;

    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_SLASH  = 8'h2F;
    localparam logic [7:0] ASCII_BSLASH = 8'h5C;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam logic [TILE_W-1:0] TILE_PLUS   = 2'd0;
    localparam logic [TILE_W-1:0] TILE_SLASH  = 2'd1;
    localparam logic [TILE_W-1:0] TILE_BSLASH = 2'd2;
    localparam logic [TILE_W-1:0] TILE_BAD    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SEND_COL,
        ST_SEND_ROW,
        ST_SEND_TILE,
        ST_SEND_EOL,
        ST_FINISH
    } tx_state_t;

    function automatic logic [7:0] tile_char(input logic [TILE_W-1:0] tile);
        logic [7:0] c;
        case (tile)
            TILE_PLUS:   c = ASCII_PLUS;
            TILE_SLASH:  c = ASCII_SLASH;
            TILE_BSLASH: c = ASCII_BSLASH;
            default:     c = ASCII_PLUS;
        endcase
        return c;
    endfunction

    // One shift-add-3 iteration: correct every nibble >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                   input logic bit_in);
        logic [BCD_W-1:0] adj;
        logic [3:0]       nib;
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            nib = bcd[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/move_transmitter_if.sv
// Handshake bundle between the game FSM and the move transmitter, including the tx line.
import move_transmitter_pkg::*;

interface move_transmitter_if;
    logic [MOVE_W-1:0] move_in;
    logic              start_transmit;
    logic              tx;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output move_in,
        output start_transmit,
        input  tx,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  move_in,
        input  start_transmit,
        output tx,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/move_transmitter_uart_tx_byte.sv
// UART 8N1 byte sender: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// ready is high only while idle; a byte is taken on valid & ready.
import move_transmitter_pkg::*;

module uart_tx_byte #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic               active;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         bit_idx;
    logic [8:0]         shreg;
    logic               tx_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            active  <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            tx_r    <= 1'b1;
        end else if (!active) begin
            if (valid) begin
                active  <= 1'b1;
                timer   <= '0;
                bit_idx <= '0;
                tx_r    <= 1'b0;
                shreg   <= {1'b1, data};
            end
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
            // bit_idx 9 is the stop bit; its end returns the sender to idle
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
                tx_r   <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx_r    <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    assign ready = !active;
    assign tx    = tx_r;

endmodule

// File: rtl/move_transmitter.sv
// Trax move transmitter: validates a binary move, converts the row to BCD and sends
// "<col><row digits><tile>LF" over UART 8N1 through uart_tx_byte.
import move_transmitter_pkg::*;

module move_transmitter #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ROW_MAX      = ROW_MAX_DEF
) (
    input  logic         clock,
    input  logic         reset,
    move_transmitter_if.slave mv
);

    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROW_MAX);

    tx_state_t         state;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic [3:0]        conv_cnt;
    logic [1:0]        dig_idx;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_sh;
    logic [TILE_W-1:0] tile_r;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_next;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              sender_ready;
    logic              byte_accept;
    logic              move_ok;

    logic [COL_W-1:0]  in_col;
    logic [ROW_W-1:0]  in_row;
    logic [TILE_W-1:0] in_tile;

    function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] b, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd2:    nib = b[11:8];
            2'd1:    nib = b[7:4];
            default: nib = b[3:0];
        endcase
        return ASCII_ZERO + {4'd0, nib};
    endfunction

    // Index of the most significant non-zero digit; a zero row still sends one '0'.
    function automatic logic [1:0] msd_index(input logic [BCD_W-1:0] b);
        if (b[11:8] != 4'd0)     return 2'd2;
        else if (b[7:4] != 4'd0) return 2'd1;
        else                     return 2'd0;
    endfunction

    assign in_col   = mv.move_in[COL_LSB  +: COL_W];
    assign in_row   = mv.move_in[ROW_LSB  +: ROW_W];
    assign in_tile  = mv.move_in[TILE_LSB +: TILE_W];
    assign move_ok  = (in_col <= COL_MAX) && (in_row <= ROW_LIMIT) && (in_tile != TILE_BAD);

    assign bcd_next    = bcd_step(bcd, row_sh[ROW_W-1]);
    assign byte_accept = byte_valid && sender_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            conv_cnt   <= '0;
            dig_idx    <= '0;
            byte_valid <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mv.start_transmit) begin
                        if (!move_ok) begin
                            error_r <= 1'b1;
                        end else begin
                            busy_r   <= 1'b1;
                            col_r    <= in_col;
                            row_sh   <= in_row;
                            tile_r   <= in_tile;
                            bcd      <= '0;
                            conv_cnt <= '0;
                            state    <= ST_CONVERT;
                        end
                    end
                end
                ST_CONVERT: begin
                    bcd    <= bcd_next;
                    row_sh <= {row_sh[ROW_W-2:0], 1'b0};
                    if (conv_cnt == 4'd11) begin
                        conv_cnt   <= '0;
                        dig_idx    <= msd_index(bcd_next);
                        byte_data  <= ASCII_AT + col_r;
                        byte_valid <= 1'b1;
                        state      <= ST_SEND_COL;
                    end else begin
                        conv_cnt <= conv_cnt + 4'd1;
                    end
                end
                ST_SEND_COL: begin
                    if (byte_accept) begin
                        byte_data <= digit_char(bcd, dig_idx);
                        state     <= ST_SEND_ROW;
                    end
                end
                ST_SEND_ROW: begin
                    if (byte_accept) begin
                        if (dig_idx == 2'd0) begin
                            byte_data <= tile_char(tile_r);
                            state     <= ST_SEND_TILE;
                        end else begin
                            dig_idx   <= dig_idx - 2'd1;
                            byte_data <= digit_char(bcd, dig_idx - 2'd1);
                        end
                    end
                end
                ST_SEND_TILE: begin
                    if (byte_accept) begin
                        byte_data <= ASCII_LF;
                        state     <= ST_SEND_EOL;
                    end
                end
                ST_SEND_EOL: begin
                    if (byte_accept) begin
                        byte_valid <= 1'b0;
                        state      <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // sender_ready returns only once the LF stop bit has fully elapsed
                    if (sender_ready) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clock (clock),
        .reset (reset),
        .data  (byte_data),
        .valid (byte_valid),
        .ready (sender_ready),
        .tx    (mv.tx)
    );

    assign mv.busy  = busy_r;
    assign mv.done  = done_r;
    assign mv.error = error_r;

endmodule

// File: tb/tb_move_transmitter.sv
// Directed bench for move_transmitter: decodes the tx line into bytes and checks frames,
// rejection, busy-ignore and mid-frame reset behaviour.
import move_transmitter_pkg::*;

module tb_move_transmitter;

    localparam int CPB = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    move_transmitter_if mv_if ();

    move_transmitter #(
        .CLKS_PER_BIT (CPB),
        .ROW_MAX      (999)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mv    (mv_if.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_mem [256];
    int         rx_wr = 0;
    int         done_cnt = 0;
    int         tx_low_cnt = 0;

    always @(posedge clock) begin
        if (mv_if.done === 1'b1) done_cnt <= done_cnt + 1;
        if (mv_if.tx === 1'b0)   tx_low_cnt <= tx_low_cnt + 1;
    end

    // UART monitor: find the start bit, then sample each bit near its middle
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clock);
            if (mv_if.tx === 1'b0 && reset === 1'b0) begin
                repeat (4) @(posedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clock);
                    b[i] = mv_if.tx;
                end
                repeat (CPB) @(posedge clock);
                rx_mem[rx_wr[7:0]] = b;
                rx_wr = rx_wr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_move(input int col, input int row, input int tile);
        mv_if.move_in        = {col[7:0], row[11:0], tile[1:0]};
        mv_if.start_transmit = 1'b1;
        @(negedge clock);
        mv_if.start_transmit = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int snap);
        int cyc;
        cyc = 0;
        while (done_cnt == snap && cyc < 1500) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_done_in_budget"}, 32'(cyc < 1500), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int n,
                               input logic [7:0] exp_b [6]);
        check({tag, "_nbytes"}, 32'(rx_wr - base), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_mem[8'(base + i)]}, {24'd0, exp_b[i]});
    endtask

    initial begin
        int base, dsnap, lsnap, esnap, cnt;
        int bad_col [3];
        int bad_row [3];
        int bad_tile[3];

        mv_if.move_in        = '0;
        mv_if.start_transmit = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_tx",    32'(mv_if.tx),    32'd1);
        check("reset_busy",  32'(mv_if.busy),  32'd0);
        check("reset_done",  32'(mv_if.done),  32'd0);
        check("reset_error", 32'(mv_if.error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // col=1 row=12 tile=1 -> "A12/\n"
        base = rx_wr; dsnap = done_cnt;
        send_move(1, 12, 1);
        check("f1_busy_high", 32'(mv_if.busy), 32'd1);
        cnt = 0;
        while (mv_if.tx !== 1'b0 && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        check("f1_start_latency", 32'(cnt <= 15), 32'd1);
        wait_done("f1", dsnap);
        check_frame("f1", base, 5, '{8'h41, 8'h31, 8'h32, 8'h2F, 8'h0A, 8'h00});
        repeat (10) @(negedge clock);
        check("f1_busy_low",   32'(mv_if.busy), 32'd0);
        check("f1_one_done",   32'(done_cnt - dsnap), 32'd1);
        check("f1_tx_idle",    32'(mv_if.tx), 32'd1);

        // col=0 row=0 tile=0 -> "@0+\n"
        base = rx_wr; dsnap = done_cnt;
        send_move(0, 0, 0);
        wait_done("f2", dsnap);
        check_frame("f2", base, 4, '{8'h40, 8'h30, 8'h2B, 8'h0A, 8'h00, 8'h00});
        repeat (10) @(negedge clock);

        // col=26 row=999 tile=2 -> "Z999\\n"
        base = rx_wr; dsnap = done_cnt;
        send_move(26, 999, 2);
        wait_done("f3", dsnap);
        check_frame("f3", base, 6, '{8'h5A, 8'h39, 8'h39, 8'h39, 8'h5C, 8'h0A});
        repeat (10) @(negedge clock);

        // rejected moves: bad tile, col just past Z, row just past the limit
        bad_col  = '{0, 27, 0};
        bad_row  = '{0, 0, 1000};
        bad_tile = '{3, 0, 0};
        for (int k = 0; k < 3; k++) begin
            base = rx_wr; lsnap = tx_low_cnt;
            send_move(bad_col[k], bad_row[k], bad_tile[k]);
            check($sformatf("rej%0d_error_pulse", k), 32'(mv_if.error), 32'd1);
            check($sformatf("rej%0d_busy", k),        32'(mv_if.busy),  32'd0);
            @(negedge clock);
            check($sformatf("rej%0d_error_clear", k), 32'(mv_if.error), 32'd0);
            repeat (30) @(negedge clock);
            check($sformatf("rej%0d_tx_high", k),   32'(tx_low_cnt - lsnap), 32'd0);
            check($sformatf("rej%0d_no_bytes", k),  32'(rx_wr - base),       32'd0);
        end

        // second request mid-frame is dropped without error
        base = rx_wr; dsnap = done_cnt; esnap = 0;
        send_move(1, 12, 1);
        repeat (200) @(negedge clock);
        send_move(5, 3, 0);
        check("ign_no_error", 32'(mv_if.error), 32'd0);
        check("ign_busy",     32'(mv_if.busy),  32'd1);
        wait_done("ign", dsnap);
        check_frame("ign", base, 5, '{8'h41, 8'h31, 8'h32, 8'h2F, 8'h0A, 8'h00});
        repeat (300) @(negedge clock);
        check("ign_one_done", 32'(done_cnt - dsnap), 32'd1);
        check("ign_nothing_queued", 32'(rx_wr - base), 32'd5);

        // reset during the data bits of the second byte
        send_move(1, 12, 1);
        repeat (115) @(negedge clock);
        check("rst_pre_busy", 32'(mv_if.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_tx_high",  32'(mv_if.tx),   32'd1);
        check("rst_busy_low", 32'(mv_if.busy), 32'd0);
        reset = 1'b0;
        repeat (150) @(negedge clock);
        lsnap = tx_low_cnt;
        repeat (20) @(negedge clock);
        check("rst_line_idle", 32'(tx_low_cnt - lsnap), 32'd0);
        base = rx_wr; dsnap = done_cnt;
        send_move(26, 999, 2);
        wait_done("post_rst", dsnap);
        check_frame("post_rst", base, 6, '{8'h5A, 8'h39, 8'h39, 8'h39, 8'h5C, 8'h0A});
        repeat (10) @(negedge clock);
        check("post_rst_busy_low", 32'(mv_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
